// File: rtl/axi_lite_arbiter.sv
// 2:1 AXI-lite arbiter: shares one memory slave between the instruction fetch
// unit (read-only) and the load/store unit (read/write). One transaction is
// outstanding at a time, grants alternate round-robin and stay locked until
// the response handshake completes.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU read master
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    // LSU read/write master
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    output logic [1:0]            lsu_bresp,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    // shared slave port
    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;   // 0 = IFU, 1 = LSU
    logic   ar_done;
    logic   aw_done;
    logic   w_done;
    logic   req_ifu;
    logic   req_lsu;
    logic   grant_lsu;

    // Round-robin pick: on contention the master that did not win last time goes next
    always_comb begin
        req_ifu   = ifu_arvalid;
        req_lsu   = lsu_arvalid | lsu_awvalid | lsu_wvalid;
        grant_lsu = req_lsu & (~req_ifu | ~last_grant);
    end

    // Next-state decode and channel steering; everything is zero unless granted
    always_comb begin
        state_next  = state;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        case (state)
            IDLE: begin
                if (req_ifu | req_lsu) begin
                    if (grant_lsu)
                        state_next = lsu_arvalid ? LSU_RD : LSU_WR;
                    else
                        state_next = IFU_RD;
                end
            end
            IFU_RD: begin
                s_araddr    = ifu_araddr;
                s_arvalid   = ifu_arvalid & ~ar_done;
                ifu_arready = s_arready & ~ar_done;
                ifu_rdata   = s_rdata;
                ifu_rresp   = s_rresp;
                ifu_rvalid  = s_rvalid;
                s_rready    = ifu_rready;
                if (s_rvalid & ifu_rready)
                    state_next = IDLE;
            end
            LSU_RD: begin
                s_araddr    = lsu_araddr;
                s_arvalid   = lsu_arvalid & ~ar_done;
                lsu_arready = s_arready & ~ar_done;
                lsu_rdata   = s_rdata;
                lsu_rresp   = s_rresp;
                lsu_rvalid  = s_rvalid;
                s_rready    = lsu_rready;
                if (s_rvalid & lsu_rready)
                    state_next = IDLE;
            end
            LSU_WR: begin
                s_awaddr    = lsu_awaddr;
                s_awvalid   = lsu_awvalid & ~aw_done;
                lsu_awready = s_awready & ~aw_done;
                s_wdata     = lsu_wdata;
                s_wstrb     = lsu_wstrb;
                s_wvalid    = lsu_wvalid & ~w_done;
                lsu_wready  = s_wready & ~w_done;
                lsu_bresp   = s_bresp;
                lsu_bvalid  = s_bvalid;
                s_bready    = lsu_bready;
                if (s_bvalid & lsu_bready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, grant history and per-channel handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (state_next != IDLE) begin
                    last_grant <= grant_lsu;
                    ar_done    <= 1'b0;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                end
            end else begin
                if (s_arvalid & s_arready) ar_done <= 1'b1;
                if (s_awvalid & s_awready) aw_done <= 1'b1;
                if (s_wvalid & s_wready)   w_done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed testbench for axi_lite_arbiter: reset, single reads, contention,
// split AW/W write, error response pass-through and reset abort.
module tb_axi_lite_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk;
    logic                rst;
    logic [ADDR_W-1:0]   ifu_araddr;
    logic                ifu_arvalid;
    logic                ifu_arready;
    logic [DATA_W-1:0]   ifu_rdata;
    logic [1:0]          ifu_rresp;
    logic                ifu_rvalid;
    logic                ifu_rready;
    logic [ADDR_W-1:0]   lsu_araddr;
    logic                lsu_arvalid;
    logic                lsu_arready;
    logic [DATA_W-1:0]   lsu_rdata;
    logic [1:0]          lsu_rresp;
    logic                lsu_rvalid;
    logic                lsu_rready;
    logic [ADDR_W-1:0]   lsu_awaddr;
    logic                lsu_awvalid;
    logic                lsu_awready;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wstrb;
    logic                lsu_wvalid;
    logic                lsu_wready;
    logic [1:0]          lsu_bresp;
    logic                lsu_bvalid;
    logic                lsu_bready;
    logic [ADDR_W-1:0]   s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;
    logic [ADDR_W-1:0]   s_awaddr;
    logic                s_awvalid;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;

    int n_assert = 0;
    int n_fail   = 0;
    int ar_cnt   = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    logic [ADDR_W-1:0] ar_log [32];
    logic exp_lsu;

    axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave-side handshake recorder
    always @(posedge clk) begin
        if (rst) begin
            if (s_arvalid && s_arready) begin
                if (ar_cnt < 32) ar_log[ar_cnt] <= s_araddr;
                ar_cnt <= ar_cnt + 1;
            end
            if (s_awvalid && s_awready) aw_cnt <= aw_cnt + 1;
            if (s_wvalid && s_wready)   w_cnt  <= w_cnt + 1;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with a pending IFU request ----------------
        rst = 1'b0;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        lsu_awaddr = '0; lsu_awvalid = 1'b0;
        lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        s_arready = 1'b1; s_rdata = 32'h1234_5678; s_rresp = 2'b00; s_rvalid = 1'b1;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
        tick(); tick(); tick();
        chk("rst_ifu_arready", ifu_arready, 0);
        chk("rst_s_arvalid",   s_arvalid, 0);
        chk("rst_s_araddr",    s_araddr, 0);
        chk("rst_ifu_rvalid",  ifu_rvalid, 0);
        chk("rst_ifu_rdata",   ifu_rdata, 0);
        chk("rst_s_rready",    s_rready, 0);
        chk("rst_s_awvalid",   s_awvalid, 0);
        chk("rst_s_wvalid",    s_wvalid, 0);

        // ---------------- single IFU read ----------------
        rst = 1'b1; s_arready = 1'b0; s_rvalid = 1'b0;
        #1;
        chk("idle_s_arvalid", s_arvalid, 0);
        tick();
        chk("ifu_grant_arvalid", s_arvalid, 1);
        chk("ifu_grant_araddr",  s_araddr, 32'h8000_0000);
        chk("ifu_arready_wait",  ifu_arready, 0);
        s_arready = 1'b1; #1;
        chk("ifu_arready", ifu_arready, 1);
        tick();
        ifu_arvalid = 1'b0; s_arready = 1'b0; #1;
        chk("ifu_ar_masked", s_arvalid, 0);
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'b00; ifu_rready = 1'b1; #1;
        chk("ifu_rvalid", ifu_rvalid, 1);
        chk("ifu_rdata",  ifu_rdata, 32'h0000_0413);
        chk("ifu_rresp",  ifu_rresp, 0);
        chk("ifu_lsu_rvalid", lsu_rvalid, 0);
        chk("ifu_s_rready", s_rready, 1);
        tick();
        #1;
        chk("ifu_back_idle_rvalid", ifu_rvalid, 0);
        chk("ifu_back_idle_rready", s_rready, 0);
        s_rvalid = 1'b0;
        chk("ar_cnt_1", ar_cnt, 1);

        // ---------------- simultaneous IFU + LSU reads ----------------
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000; lsu_rready = 1'b1;
        s_arready = 1'b1; #1;
        chk("sim_idle_arvalid", s_arvalid, 0);
        chk("sim_idle_lsu_arready", lsu_arready, 0);
        tick();
        chk("sim_lsu_first_addr", s_araddr, 32'h8000_1000);
        chk("sim_lsu_arready", lsu_arready, 1);
        chk("sim_ifu_held", ifu_arready, 0);
        tick();
        lsu_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_2222; #1;
        chk("sim_no_double_ar", s_arvalid, 0);
        chk("sim_lsu_rvalid", lsu_rvalid, 1);
        chk("sim_lsu_rdata", lsu_rdata, 32'h1111_2222);
        chk("sim_ifu_rvalid", ifu_rvalid, 0);
        chk("sim_ifu_rdata", ifu_rdata, 0);
        tick();
        s_rvalid = 1'b0; #1;
        chk("sim_gap_arvalid", s_arvalid, 0);
        tick();
        chk("sim_ifu_second_addr", s_araddr, 32'h8000_0000);
        chk("sim_ifu_arready", ifu_arready, 1);
        tick();
        ifu_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h3333_4444; #1;
        chk("sim_ifu_rdata2", ifu_rdata, 32'h3333_4444);
        tick();
        s_rvalid = 1'b0; #1;
        chk("sim_ar_cnt", ar_cnt, 3);
        chk("sim_ar_order0", ar_log[1], 32'h8000_1000);
        chk("sim_ar_order1", ar_log[2], 32'h8000_0000);

        // ---------------- LSU write, W two cycles ahead of AW ----------------
        lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011; #1;
        tick();
        chk("wr_s_wvalid", s_wvalid, 1);
        chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("wr_s_wstrb", s_wstrb, 4'b0011);
        chk("wr_s_awvalid_early", s_awvalid, 0);
        s_wready = 1'b1; #1;
        chk("wr_lsu_wready", lsu_wready, 1);
        tick();
        lsu_wvalid = 1'b0; ifu_arvalid = 1'b1; #1;
        chk("wr_w_masked", s_wvalid, 0);
        chk("wr_ifu_held_ar", s_arvalid, 0);
        chk("wr_ifu_held_rdy", ifu_arready, 0);
        tick();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_2000; s_awready = 1'b1; #1;
        chk("wr_s_awvalid", s_awvalid, 1);
        chk("wr_s_awaddr", s_awaddr, 32'h8000_2000);
        chk("wr_lsu_awready", lsu_awready, 1);
        tick();
        lsu_awvalid = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b00; lsu_bready = 1'b1; #1;
        chk("wr_aw_masked", s_awvalid, 0);
        chk("wr_lsu_bvalid", lsu_bvalid, 1);
        chk("wr_lsu_bresp", lsu_bresp, 0);
        chk("wr_s_bready", s_bready, 1);
        chk("wr_ifu_held_b", ifu_arready, 0);
        tick();
        s_bvalid = 1'b0; #1;
        chk("wr_aw_cnt", aw_cnt, 1);
        chk("wr_w_cnt", w_cnt, 1);
        chk("wr_idle_arvalid", s_arvalid, 0);
        tick();
        chk("wr_ifu_after_b", s_arvalid, 1);
        chk("wr_ifu_after_b_addr", s_araddr, 32'h8000_0000);
        tick();
        ifu_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0013; #1;
        tick();
        s_rvalid = 1'b0; #1;
        chk("wr_ar_cnt", ar_cnt, 4);

        // ---------------- continuous contention, 6 reads each ----------------
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_lsu = (i % 2 == 0);
            #1;
            chk("cont_idle_arvalid", s_arvalid, 0);
            tick();
            chk("cont_araddr", s_araddr, exp_lsu ? 32'h8000_1000 : 32'h8000_0000);
            chk("cont_win_arready", exp_lsu ? lsu_arready : ifu_arready, 1);
            chk("cont_lose_arready", exp_lsu ? ifu_arready : lsu_arready, 0);
            tick();
            s_rvalid = 1'b1; s_rdata = 32'(i); #1;
            chk("cont_no_double_ar", s_arvalid, 0);
            chk("cont_win_rvalid", exp_lsu ? lsu_rvalid : ifu_rvalid, 1);
            chk("cont_lose_rvalid", exp_lsu ? ifu_rvalid : lsu_rvalid, 0);
            chk("cont_win_rdata", exp_lsu ? lsu_rdata : ifu_rdata, 32'(i));
            tick();
            s_rvalid = 1'b0;
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; #1;
        chk("cont_ar_cnt", ar_cnt, 16);

        // ---------------- SLVERR on an LSU read ----------------
        lsu_arvalid = 1'b1; #1;
        tick();
        chk("err_lsu_grant", lsu_arready, 1);
        tick();
        lsu_arvalid = 1'b0; s_rvalid = 1'b1; s_rresp = 2'b10; s_rdata = 32'h0000_0BAD; #1;
        chk("err_lsu_rresp", lsu_rresp, 2'b10);
        chk("err_lsu_rvalid", lsu_rvalid, 1);
        tick();
        s_rvalid = 1'b0; s_rresp = 2'b00; ifu_arvalid = 1'b1; #1;
        chk("err_idle_arvalid", s_arvalid, 0);
        tick();
        chk("err_next_grant", s_arvalid, 1);
        chk("err_next_addr", s_araddr, 32'h8000_0000);
        chk("err_ar_cnt", ar_cnt, 17);

        // ---------------- reset mid-transaction ----------------
        rst = 1'b0; #1;
        chk("abort_s_arvalid", s_arvalid, 0);
        chk("abort_ifu_arready", ifu_arready, 0);
        tick();
        rst = 1'b1; ifu_arvalid = 1'b0; #1;
        tick();
        chk("abort_idle_arvalid", s_arvalid, 0);
        chk("abort_ar_cnt", ar_cnt, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- 2:1 AXI-lite arbiter that shares the single memory slave (AXI2MEM bridge) between the instruction fetch unit (IFU, read-only master) and the load/store unit (LSU, read/write master).
- Exactly one transaction is outstanding at the slave at any time.
- Grants are round-robin and locked for the full transaction.
- Sits between the IFU/LSU master ports and the slave port of the memory bridge.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels; wstrb width is DATA_W/8

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- ifu_araddr, ifu_arvalid / ifu_arready  in ADDR_W,1 / out 1  IFU AR channel
- ifu_rdata, ifu_rresp, ifu_rvalid / ifu_rready  out DATA_W,2,1 / in 1  IFU R channel
- lsu_araddr, lsu_arvalid / lsu_arready  in ADDR_W,1 / out 1  LSU AR channel
- lsu_rdata, lsu_rresp, lsu_rvalid / lsu_rready  out DATA_W,2,1 / in 1  LSU R channel
- lsu_awaddr, lsu_awvalid / lsu_awready  in ADDR_W,1 / out 1  LSU AW channel
- lsu_wdata, lsu_wstrb, lsu_wvalid / lsu_wready  in DATA_W,DATA_W/8,1 / out 1  LSU W channel
- lsu_bresp, lsu_bvalid / lsu_bready  out 2,1 / in 1  LSU B channel
- s_araddr, s_arvalid / s_arready  out ADDR_W,1 / in 1  slave AR
- s_rdata, s_rresp, s_rvalid / s_rready  in DATA_W,2,1 / out 1  slave R
- s_awaddr, s_awvalid / s_awready  out ADDR_W,1 / in 1  slave AW
- s_wdata, s_wstrb, s_wvalid / s_wready  out DATA_W,DATA_W/8,1 / in 1  slave W
- s_bresp, s_bvalid / s_bready  in 2,1 / out 1  slave B

Behaviour:
- State register, values: IDLE, IFU_RD, LSU_RD, LSU_WR.
- Additional registers: last_grant (0 = IFU, 1 = LSU) and done flags ar_done, aw_done, w_done.
- Reset (rst = 0, async):
  - state = IDLE, last_grant = IFU, all done flags = 0.
  - Every valid/ready output is 0; all data/addr/resp outputs are 0.
- IDLE:
  - No channel is forwarded; all master readys and slave valids are 0.
  - req_ifu = ifu_arvalid; req_lsu = lsu_arvalid | lsu_awvalid | lsu_wvalid.
  - Only req_ifu: next state IFU_RD. Only req_lsu: next state LSU_RD if lsu_arvalid, else LSU_WR.
  - Both: the master not equal to last_grant wins. The loser's valids stay pending, and its readys stay 0.
  - LSU with both lsu_arvalid and write valids high: read is served first.
  - Arbitration latency is 1 cycle: a request seen in IDLE at cycle N is forwarded to the slave from cycle N+1.
  - On leaving IDLE, last_grant is updated to the winner and done flags are cleared.
- IFU_RD / LSU_RD:
  - Granted AR is forwarded combinationally to the slave while ar_done = 0.
  - On s_arvalid & s_arready, set ar_done; afterwards s_arvalid is forced 0.
  - R channel is forwarded: s_rdata/s_rresp/s_rvalid go to the granted master, and its rready goes to s_rready.
  - The other master sees rvalid = 0 and rdata/rresp = 0.
  - On s_rvalid & s_rready, next state is IDLE.
- LSU_WR:
  - AW and W are forwarded independently, each masked after its handshake via aw_done/w_done. Either order is legal, as is both in the same cycle.
  - B is forwarded to the LSU; on s_bvalid & s_bready, next state is IDLE.
- IFU is never forwarded onto AW/W/B; ifu_arready is 0 outside IFU_RD (and after ar_done).
- Responses (rresp/bresp, including SLVERR 2'b10) pass through unmodified.
- Back-to-back: the minimum gap between transactions is one IDLE cycle.
- Valid deassertion by a master after grant but before its handshake is a protocol violation. No recovery is required; the FSM stays in the grant state.
- Reset mid-transaction aborts immediately to IDLE. Slave-side recovery is the slave's own reset.

Test Plan:
- Reset: rst = 0 for 3 cycles with ifu_arvalid = 1 -> all readys/valids 0; after release, IFU_RD is entered 1 cycle after the first sampled edge.
- Single IFU read: araddr = 0x8000_0000; slave returns rdata = 0x0000_0413, rresp = 0 after 2 cycles -> ifu_rdata = 0x0000_0413, ifu_rvalid is 1 for one cycle, lsu_rvalid stays 0, state returns to IDLE.
- Simultaneous IFU read (0x8000_0000) and LSU read (0x8000_1000) right after reset -> LSU is served first (last_grant = IFU), then IFU. The slave sees exactly two AR handshakes in that order.
- LSU write with wvalid 2 cycles before awvalid: awaddr = 0x8000_2000, wdata = 0xDEAD_BEEF, wstrb = 4'b0011 -> exactly one AW and one W handshake at the slave, lsu_bresp = 0, and IFU is held off until after B.
- Continuous contention, 6 requests each -> grants alternate LSU, IFU, LSU, ... with no starvation and no double AR at the slave.
- Slave rresp = 2'b10 on an LSU read -> lsu_rresp = 2'b10 and the arbiter returns to IDLE normally.
